// File: rtl/tile_sched.sv
// Weight-tile job sequencer for the 32x32 core: per tile it runs a weight load, a settle gap,
// an activation stream and a pipeline drain, alternating the weight bank pair on each tile.
module tile_sched #(
   parameter int GAP_CYC   = 4,
   parameter int DRAIN_CYC = 72
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  cfg_tiles,
   input  logic [11:0] cfg_act_len,
   input  logic [14:0] cfg_w_base,
   input  logic [14:0] cfg_a_base,
   output logic        w_ren_a,
   output logic        w_ren_b,
   output logic [14:0] w_raddr,
   output logic        act_ren,
   output logic [14:0] act_raddr,
   output logic        start_calc,
   output logic        busy,
   output logic        done,
   output logic [7:0]  tile_idx
);

   typedef enum logic [2:0] {IDLE, WLOAD, WGAP, ACT, DRAIN, DONE} state_t;

   localparam logic [6:0] GAP_LAST   = 7'(GAP_CYC - 1);
   localparam logic [6:0] DRAIN_LAST = 7'(DRAIN_CYC - 1);

   state_t      state, state_n;
   logic [4:0]  row, row_n;
   logic [11:0] act_cnt, act_cnt_n;
   logic [6:0]  wait_cnt, wait_cnt_n;
   logic [7:0]  tile, tile_n;

   logic [7:0]  tiles_q;
   logic [11:0] act_len_q;
   logic [14:0] w_base_q, a_base_q;

   logic        accept;
   logic [14:0] w_base_n;
   logic [14:0] w_raddr_n, act_raddr_n;
   logic        w_en_n, act_en_n;

   assign accept = (state == IDLE) && start;

   always_comb begin
      state_n    = state;
      row_n      = row;
      act_cnt_n  = act_cnt;
      wait_cnt_n = wait_cnt;
      tile_n     = tile;
      case (state)
         IDLE: if (start) begin
            tile_n  = 8'd0;
            row_n   = 5'd0;
            state_n = (cfg_tiles != 8'd0) ? WLOAD : DONE;
         end
         WLOAD: if (row == 5'd31) begin
            state_n    = WGAP;
            wait_cnt_n = 7'd0;
         end else begin
            row_n = row + 5'd1;
         end
         WGAP: if (wait_cnt == GAP_LAST) begin
            wait_cnt_n = 7'd0;
            act_cnt_n  = 12'd0;
            state_n    = (act_len_q == 12'd0) ? DRAIN : ACT;
         end else begin
            wait_cnt_n = wait_cnt + 7'd1;
         end
         ACT: if (act_cnt == act_len_q - 12'd1) begin
            state_n    = DRAIN;
            wait_cnt_n = 7'd0;
         end else begin
            act_cnt_n = act_cnt + 12'd1;
         end
         DRAIN: if (wait_cnt == DRAIN_LAST) begin
            if ({1'b0, tile} + 9'd1 < {1'b0, tiles_q}) begin
               tile_n  = tile + 8'd1;
               row_n   = 5'd0;
               state_n = WLOAD;
            end else begin
               state_n = DONE;
            end
         end else begin
            wait_cnt_n = wait_cnt + 7'd1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from next-state values so each enable lines up with its own phase cycle.
   assign w_base_n    = accept ? cfg_w_base : w_base_q;
   assign w_en_n      = (state_n == WLOAD);
   assign act_en_n    = (state_n == ACT);
   assign w_raddr_n   = w_base_n + 15'({tile_n, 5'b0}) + 15'(row_n);
   assign act_raddr_n = a_base_q + 15'(act_cnt_n);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         row        <= 5'd0;
         act_cnt    <= 12'd0;
         wait_cnt   <= 7'd0;
         tile       <= 8'd0;
         tiles_q    <= 8'd0;
         act_len_q  <= 12'd0;
         w_base_q   <= 15'd0;
         a_base_q   <= 15'd0;
         w_ren_a    <= 1'b0;
         w_ren_b    <= 1'b0;
         w_raddr    <= 15'd0;
         act_ren    <= 1'b0;
         act_raddr  <= 15'd0;
         start_calc <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state    <= state_n;
         row      <= row_n;
         act_cnt  <= act_cnt_n;
         wait_cnt <= wait_cnt_n;
         tile     <= tile_n;
         if (accept) begin
            tiles_q   <= cfg_tiles;
            act_len_q <= cfg_act_len;
            w_base_q  <= cfg_w_base;
            a_base_q  <= cfg_a_base;
         end
         w_ren_a    <= w_en_n & ~tile_n[0];
         w_ren_b    <= w_en_n & tile_n[0];
         w_raddr    <= w_en_n ? w_raddr_n : 15'd0;
         act_ren    <= act_en_n;
         act_raddr  <= act_en_n ? act_raddr_n : 15'd0;
         start_calc <= act_en_n && (act_cnt_n == 12'd0) && (tile_n == 8'd0);
         busy       <= (state_n != IDLE);
         done       <= (state_n == DONE);
      end
   end

   assign tile_idx = tile;

endmodule

// File: doc/tile_sched.md
# tile_sched

Job sequencer for the 32x32 compute core. On a `start` pulse it runs a configurable number of weight tiles through the core. For each tile it:
- issues 32 weight-row reads to the ping-ponged weight banks (4/5 or 6/7),
- waits for the weight-load pipeline to settle,
- streams the activation vectors,
- waits for the array, post-process and de-skew pipelines to drain.

It sits between the host/config registers and the core's SRAM read ports. It drives the core's `start_calc`, and the SRAM read-enables that become `brvalid_*` and `act_pe_valid`.

## Interface
Parameters:
- `GAP_CYC`, 4: idle cycles between the last weight read and the first activation read. Covers SRAM read latency plus the 2-stage `load_weight_en` delay.
- `DRAIN_CYC`, 72: cycles waited after the last activation read. Covers 32 array + 3 post-process + 32 de-skew + margin.

Ports (all inputs are sampled at `posedge clk`):
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle job start; ignored while `busy`=1.
- `cfg_tiles`  in  8  number of weight tiles in the job.
- `cfg_act_len`  in  12  activation vectors per tile.
- `cfg_w_base`  in  15  weight base address.
- `cfg_a_base`  in  15  activation base address.
- `w_ren_a`  out  1  read enable, weight banks 4/5 (even tiles).
- `w_ren_b`  out  1  read enable, weight banks 6/7 (odd tiles).
- `w_raddr`  out  15  weight read address, shared by both bank pairs.
- `act_ren`  out  1  activation read enable.
- `act_raddr`  out  15  activation read address.
- `start_calc`  out  1  one-cycle pulse to the core; resets the result write address.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle job-complete pulse.
- `tile_idx`  out  8  index of the current tile.

## Operation
Config capture:
- All `cfg_*` inputs are latched on an accepted `start`.
- Later changes to `cfg_*` have no effect until the next job.

States: IDLE, WLOAD, WGAP, ACT, DRAIN, DONE.
- **IDLE.** `start`=1 with latched tiles > 0 → WLOAD; `tile_idx`=0 and the row counter is cleared. `start`=1 with `cfg_tiles`=0 → DONE directly; no reads are issued.
- **WLOAD** (32 cycles, row r = 0..31):
  - the bank enable is asserted: `w_ren_a` if `tile_idx[0]`=0, else `w_ren_b`; exactly one of them is high;
  - `w_raddr` = w_base + tile_idx*32 + r, truncated mod 2^15.
  - After r=31 → WGAP.
- **WGAP** (`GAP_CYC` cycles): no enables. Then → ACT; if latched act_len=0, → DRAIN instead.
- **ACT** (act_len cycles, i = 0..act_len-1):
  - `act_ren`=1 and `act_raddr` = a_base + i, mod 2^15;
  - activations are reused for every tile;
  - `start_calc`=1 only in the first ACT cycle of tile 0.
  - Then → DRAIN.
- **DRAIN** (`DRAIN_CYC` cycles): no enables.
  - If tile_idx+1 < tiles: increment `tile_idx` and go → WLOAD.
  - Otherwise → DONE.
- **DONE** (1 cycle): `done`=1, `busy`=1, then → IDLE. `tile_idx` holds its final value.

Enable exclusivity: weight enables and `act_ren` are never high in the same cycle.

Counters:
- 5-bit row counter, 12-bit activation counter, 7-bit generic wait counter.
- A counter reaching its terminal value and the state change happen in the same cycle.
- No cycle is lost between phases.

`start` while `busy`=1 is dropped. It is not queued.

## Timing
- Reset value of every output: 0, including `w_raddr`, `act_raddr` and `tile_idx`.
- Assertion of `rst_n`=0 at any time returns the block to IDLE immediately. Any in-flight job is abandoned; no `done` is produced.
- All outputs are registered.
- Latencies, with an accepted `start` in cycle 0:
  - first `w_ren` in cycle 1;
  - `busy` rises in cycle 1.
- Per-tile length: 32 + `GAP_CYC` + act_len + `DRAIN_CYC` cycles.
- `done` occurs in cycle 1 + tiles*(per-tile length).
- Tile boundary: the last DRAIN cycle of tile t is followed directly by WLOAD row 0 of tile t+1.
- Job boundary: `start` is accepted again in the cycle after `done`, because the block is then in IDLE.

## Test plan
- **Single tile.** Defaults, tiles=1, act_len=4, w_base=0x100, a_base=0x20, `start` at cycle 0:
  - `w_ren_a` in cycles 1..32 with addresses 0x100..0x11F;
  - `act_ren` in cycles 37..40 with addresses 0x20..0x23;
  - `start_calc` in cycle 37 only;
  - `done` in cycle 113; `w_ren_b` is never asserted.
- **Ping-pong.** tiles=3, act_len=2:
  - tile 1 uses `w_ren_b` with addresses base+32..base+63;
  - tile 2 uses `w_ren_a` with base+64..;
  - `start_calc` pulses once;
  - `done` in cycle 1 + 3*110 = 331.
- **Zero cases.**
  - tiles=0 → `done` in cycle 1, no enables.
  - act_len=0, tiles=1 → WLOAD then DRAIN; no `act_ren`; no `start_calc`; `done` in cycle 109.
- **Start while busy.** A second `start` in cycle 50 is ignored:
  - only one `done`;
  - config changes made in cycle 50 do not alter any addresses.
- **Reset mid-job.** `rst_n`=0 in cycle 20 of WLOAD:
  - all outputs are 0 in the same cycle;
  - after release, a new `start` runs the full sequence from tile 0.
- **Address wrap.** w_base=0x7FF0:
  - row 16 reads address 0x0000;
  - a_base=0x7FFF, act_len=2 → activation addresses 0x7FFF then 0x0000.
